// File: rtl/lifo1i1o_ctrl_pkg.sv
// rtl/lifo1i1o_ctrl_pkg.sv - shared types and width helper for the LIFO controller
package lifo1i1o_ctrl_pkg;

   typedef enum logic {
      ZS_IDLE  = 1'b0,
      ZS_SWEEP = 1'b1
   } zs_state_e;

   function automatic int lifo_clog2(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/lifo1i1o_zsweep.sv
// rtl/lifo1i1o_zsweep.sv - post-reset zeroize sweep FSM and address counter
module lifo1i1o_zsweep
   import lifo1i1o_ctrl_pkg::*;
#(
   parameter int SZ = 16,
   parameter int AW = lifo_clog2(SZ)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          busy_o,
   output logic [AW-1:0] zc_o
);

   zs_state_e     state_q, state_d;
   logic [AW-1:0] zc_q, zc_d;

   always_comb begin
      state_d = state_q;
      zc_d    = zc_q;
      if (state_q == ZS_SWEEP) begin
         zc_d = zc_q + 1'b1;
         if (zc_q == AW'(SZ - 1)) state_d = ZS_IDLE;
      end
   end

   // Reset parks the FSM in SWEEP at entry 0, so a reset mid-sweep restarts it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ZS_SWEEP;
         zc_q    <= '0;
      end else begin
         state_q <= state_d;
         zc_q    <= zc_d;
      end
   end

   assign busy_o = (state_q == ZS_SWEEP);
   assign zc_o   = zc_q;

endmodule

// File: rtl/lifo1i1o_ctrl.sv
// rtl/lifo1i1o_ctrl.sv - stack controller driving an external ram1i1o; optional LIFO1I1O_ZEROIZE_EN
module lifo1i1o_ctrl
   import lifo1i1o_ctrl_pkg::*;
#(
   parameter int SZ = 16,
   parameter int DW = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DW-1:0]              data_i,
   output logic [DW-1:0]              data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [lifo_clog2(SZ):0]    usage_o,
   output logic                       busy_o,
   output logic                       ram_we_o,
   output logic [lifo_clog2(SZ)-1:0]  ram_addr_o,
   output logic [DW-1:0]              ram_data_o,
   input  logic [DW-1:0]              ram_data_i
);

   localparam int AW = lifo_clog2(SZ);
   localparam int UW = AW + 1;

   logic [UW-1:0] sp_q, sp_d;
   logic [UW-1:0] sp_m1;
   logic [AW-1:0] st_addr;
   logic          full, empty, pe, po, busy;

   assign full  = (sp_q == UW'(SZ));
   assign empty = (sp_q == '0);
   assign sp_m1 = sp_q - 1'b1;

   // Requests are dropped while reset or the sweep owns the RAM port.
   assign pe = push_i & (~full | pop_i) & ~rst_i & ~busy;
   assign po = pop_i & ~empty & ~rst_i & ~busy;

   assign st_addr = (pe & ~po) ? sp_q[AW-1:0] : sp_m1[AW-1:0];

   always_comb begin
      sp_d = sp_q;
      case ({pe, po})
         2'b10:   sp_d = sp_q + 1'b1;
         2'b01:   sp_d = sp_m1;
         default: sp_d = sp_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) sp_q <= '0;
      else       sp_q <= sp_d;
   end

`ifdef LIFO1I1O_ZEROIZE_EN
   logic [AW-1:0] zc;

   lifo1i1o_zsweep #(
      .SZ (SZ),
      .AW (AW)
   ) u_zsweep (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .busy_o (busy),
      .zc_o   (zc)
   );

   assign ram_we_o   = busy ? ~rst_i : pe;
   assign ram_addr_o = busy ? zc : st_addr;
   assign ram_data_o = busy ? '0 : data_i;
`else
   assign busy       = 1'b0;
   assign ram_we_o   = pe;
   assign ram_addr_o = st_addr;
   assign ram_data_o = data_i;
`endif

   assign data_o  = ram_data_i;
   assign full_o  = full;
   assign empty_o = empty;
   assign usage_o = sp_q;
   assign busy_o  = busy;

endmodule

// File: tb/tb_lifo1i1o_ctrl.sv
// tb/tb_lifo1i1o_ctrl.sv - scoreboard bench for lifo1i1o_ctrl with a behavioural ram1i1o
module tb_lifo1i1o_ctrl;

   localparam int SZ = 16;
   localparam int DW = 32;
   localparam int AW = $clog2(SZ);

   typedef enum int {K_DATA, K_USAGE, K_FULL, K_EMPTY, K_BUSY, K_RAM, K_ADDR, K_WE} kind_e;

   typedef struct {
      string       name;
      int          cyc;
      kind_e       kind;
      logic [31:0] val;
      int          addr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          push_i = 1'b0;
   logic          pop_i = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic [DW-1:0] data_o;
   logic          full_o, empty_o, busy_o, ram_we_o;
   logic [AW:0]   usage_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_data_o, ram_rdata;

   logic [DW-1:0] mem [SZ];
   bit            pre_done = 1'b0;
   int            cyc = 0;
   int            checks = 0;
   int            fails = 0;
   exp_t          exp_q[$];

   always #5 clk = ~clk;

   lifo1i1o_ctrl #(.SZ(SZ), .DW(DW)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .push_i     (push_i),
      .pop_i      (pop_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .usage_o    (usage_o),
      .busy_o     (busy_o),
      .ram_we_o   (ram_we_o),
      .ram_addr_o (ram_addr_o),
      .ram_data_o (ram_data_o),
      .ram_data_i (ram_rdata)
   );

   // ram1i1o model: synchronous write, asynchronous read, nonzero preload
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!pre_done) begin
         for (int i = 0; i < SZ; i++) mem[i] <= 32'hDEAD_0000 + i;
         pre_done <= 1'b1;
      end else if (ram_we_o) begin
         mem[ram_addr_o] <= ram_data_o;
      end
   end
   assign ram_rdata = mem[ram_addr_o];

   task automatic check_one(input exp_t e);
      logic [31:0] act;
      case (e.kind)
         K_DATA:  act = data_o;
         K_USAGE: act = 32'(usage_o);
         K_FULL:  act = 32'(full_o);
         K_EMPTY: act = 32'(empty_o);
         K_BUSY:  act = 32'(busy_o);
         K_RAM:   act = mem[e.addr];
         K_ADDR:  act = 32'(ram_addr_o);
         default: act = 32'(ram_we_o);
      endcase
      checks++;
      if (act !== e.val) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc, act, e.val);
      end
   endtask

   always @(negedge clk) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc == cyc) begin
            check_one(exp_q[i]);
            exp_q.delete(i);
         end
      end
   end

   task automatic drive(input logic r, input logic pu, input logic po, input logic [31:0] d);
      @(posedge clk);
      #1;
      rst_i = r; push_i = pu; pop_i = po; data_i = d;
   endtask

   task automatic expect_at(input string n, input kind_e k, input int ofs,
                            input logic [31:0] v, input int a = 0);
      exp_t e;
      e.name = n; e.cyc = cyc + ofs; e.kind = k; e.val = v; e.addr = a;
      exp_q.push_back(e);
   endtask

   task automatic idle_until_ready();
      for (int i = 0; i < 40 && busy_o === 1'b1; i++) drive(0, 0, 0, 0);
   endtask

   initial begin
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);

`ifdef LIFO1I1O_ZEROIZE_EN
      for (int k = 0; k < SZ; k++) begin
         drive(0, 1, 0, 32'h77);
         expect_at("zs_busy", K_BUSY, 0, 1);
         expect_at("zs_addr", K_ADDR, 0, k);
         expect_at("zs_we", K_WE, 0, 1);
         expect_at("zs_usage", K_USAGE, 0, 0);
      end
      drive(0, 0, 0, 0);
      expect_at("zs_done", K_BUSY, 0, 0);
      expect_at("zs_usage_after", K_USAGE, 0, 0);
      for (int a = 0; a < SZ; a++) expect_at("zs_ram_zero", K_RAM, 0, 0, a);
      drive(1, 0, 0, 0);
      for (int k = 0; k < 7; k++) drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int k = 0; k < SZ; k++) begin
         drive(0, 0, 0, 0);
         expect_at("zs_restart_addr", K_ADDR, 0, k);
         expect_at("zs_restart_busy", K_BUSY, 0, 1);
      end
      drive(0, 0, 0, 0);
      expect_at("zs_restart_done", K_BUSY, 0, 0);
`else
      drive(0, 0, 0, 0);
      expect_at("rst_busy", K_BUSY, 0, 0);
`endif

      drive(0, 0, 0, 0);
      expect_at("rst_usage", K_USAGE, 0, 0);
      expect_at("rst_empty", K_EMPTY, 0, 1);
      expect_at("rst_full", K_FULL, 0, 0);

      drive(0, 1, 0, 32'hA);
      drive(0, 1, 0, 32'hB);
      drive(0, 1, 0, 32'hC);
      drive(0, 0, 0, 0);
      expect_at("push3_usage", K_USAGE, 0, 3);
      expect_at("push3_top", K_DATA, 0, 32'hC);
      expect_at("push3_ram0", K_RAM, 0, 32'hA, 0);
      expect_at("push3_ram1", K_RAM, 0, 32'hB, 1);
      expect_at("push3_ram2", K_RAM, 0, 32'hC, 2);

      drive(0, 0, 1, 0); expect_at("pop_c", K_DATA, 0, 32'hC);
      drive(0, 0, 1, 0); expect_at("pop_b", K_DATA, 0, 32'hB);
      drive(0, 0, 1, 0); expect_at("pop_a", K_DATA, 0, 32'hA);
      drive(0, 0, 0, 0);
      expect_at("pop3_empty", K_EMPTY, 0, 1);
      expect_at("pop3_usage", K_USAGE, 0, 0);
`ifndef LIFO1I1O_ZEROIZE_EN
      expect_at("empty_addr_wrap", K_ADDR, 0, SZ - 1);
`endif

      for (int i = 0; i < SZ; i++) drive(0, 1, 0, i + 1);
      drive(0, 1, 0, 32'hFF);
      expect_at("fill_full", K_FULL, 0, 1);
      expect_at("fill_we_blocked", K_WE, 0, 0);
      drive(0, 0, 0, 0);
      expect_at("ovf_usage", K_USAGE, 0, SZ);
      expect_at("ovf_ram15", K_RAM, 0, 32'h10, 15);
      expect_at("ovf_top", K_DATA, 0, 32'h10);

      for (int i = 0; i < SZ; i++) begin
         drive(0, 0, 1, 0);
         expect_at("drain_data", K_DATA, 0, SZ - i);
      end
      drive(0, 0, 1, 0);
      expect_at("unf_empty", K_EMPTY, 0, 1);
      drive(0, 0, 0, 0);
      expect_at("unf_usage", K_USAGE, 0, 0);

      drive(0, 1, 0, 32'h11);
      drive(0, 1, 0, 32'h22);
      drive(0, 1, 1, 32'h33);
      expect_at("repl_old_top", K_DATA, 0, 32'h22);
      expect_at("repl_usage_during", K_USAGE, 0, 2);
      drive(0, 0, 0, 0);
      expect_at("repl_usage", K_USAGE, 0, 2);
      expect_at("repl_new_top", K_DATA, 0, 32'h33);
      for (int i = 0; i < SZ - 2; i++) drive(0, 1, 0, 32'h40 + i);
      drive(0, 1, 1, 32'h55);
      expect_at("repl_full_old_top", K_DATA, 0, 32'h4D);
      expect_at("repl_full_flag", K_FULL, 0, 1);
      drive(0, 0, 0, 0);
      expect_at("repl_full_usage", K_USAGE, 0, SZ);
      expect_at("repl_full_top", K_DATA, 0, 32'h55);

      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      idle_until_ready();
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 32'h61 + i);
      drive(0, 0, 0, 0);
      expect_at("pre_rst_usage", K_USAGE, 0, 5);
      drive(1, 1, 0, 32'h99);
      expect_at("rst_push_we", K_WE, 0, 0);
      drive(0, 0, 0, 0);
      expect_at("rst_mid_usage", K_USAGE, 0, 0);
      expect_at("rst_mid_empty", K_EMPTY, 0, 1);
`ifndef LIFO1I1O_ZEROIZE_EN
      expect_at("rst_mid_ram5", K_RAM, 0, 32'h43, 5);
`endif

      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         fails++;
         $display("FAIL %s never checked (cyc=%0d)", e.name, e.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
